iter_div_unit: RTL and testbench

ITER_DIV_UNIT -- requirements
Module: iter_div_unit

---
 rtl/iter_div_unit_if.sv | 53 +++++
 rtl/iter_div_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_iter_div_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/iter_div_unit_if.sv
// -----------------------------------------------------------------------------
// iter_div_unit_if
// Handshake and data bundle between register-read / writeback and the
// iterative divider. Signal suffixes are seen from the divider's side:
// *_i are driven by the issuing stage, *_o are driven by the divider.
//
//   recoverFlag_i  pipeline flush, kills any in-flight op
//   valid_i        new divide op
//   src1Data_i     dividend
//   src2Data_i     divisor
//   isSigned_i     1 = DIV/REM, 0 = DIVU/REMU
//   isRem_i        1 = remainder, 0 = quotient
//   alID_i         active-list ID of the op
//   phyDest_i      physical destination tag of the op
//   ready_o        an op may be accepted this cycle
//   resultValid_o  one-cycle writeback pulse
//   result_o       quotient or remainder (zero when resultValid_o = 0)
//   alID_o         active-list ID of the result (zero when idle)
//   phyDest_o      destination tag of the result (zero when idle)
//
// Modports: master = issuing side / bench, slave = divider.
// -----------------------------------------------------------------------------
interface iter_div_unit_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 7,
   parameter int PHY_W  = 7
);
   logic              recoverFlag_i;
   logic              valid_i;
   logic [DATA_W-1:0] src1Data_i;
   logic [DATA_W-1:0] src2Data_i;
   logic              isSigned_i;
   logic              isRem_i;
   logic [TAG_W-1:0]  alID_i;
   logic [PHY_W-1:0]  phyDest_i;
   logic              ready_o;
   logic              resultValid_o;
   logic [DATA_W-1:0] result_o;
   logic [TAG_W-1:0]  alID_o;
   logic [PHY_W-1:0]  phyDest_o;

   modport master (
      output recoverFlag_i, valid_i, src1Data_i, src2Data_i, isSigned_i,
             isRem_i, alID_i, phyDest_i,
      input  ready_o, resultValid_o, result_o, alID_o, phyDest_o
   );

   modport slave (
      input  recoverFlag_i, valid_i, src1Data_i, src2Data_i, isSigned_i,
             isRem_i, alID_i, phyDest_i,
      output ready_o, resultValid_o, result_o, alID_o, phyDest_o
   );
endinterface

// File: rtl/iter_div_unit.sv
// -----------------------------------------------------------------------------
// iter_div_unit
// Iterative radix-2 restoring divider for signed/unsigned DIV/REM.
// One op at a time: IDLE accepts, BUSY runs DATA_W shift/subtract steps on
// operand magnitudes, DONE sign-corrects and emits a one-cycle writeback pulse.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-high reset
//   bus    iter_div_unit_if.slave (see interface file for signal list)
//
// Configuration macro:
//   ITER_DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow
//                          (most-negative / -1) skip BUSY and go straight to
//                          DONE. Otherwise every op takes the full DATA_W steps.
// -----------------------------------------------------------------------------
module iter_div_unit #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 7,
   parameter int PHY_W  = 7
) (
   input  logic            clk,
   input  logic            reset,
   iter_div_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   // Two's-complement negate (modular, so MOST_NEG maps to itself)
   function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] x);
      return (~x) + DATA_W'(1);
   endfunction

   function automatic logic [DATA_W-1:0] f_cond_neg(input logic [DATA_W-1:0] x,
                                                   input logic neg);
      return neg ? f_neg(x) : x;
   endfunction

   state_t            state_q, state_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] quo_q, quo_d;       // dividend shifts out, quotient shifts in
   logic [DATA_W-1:0] rem_q, rem_d;       // partial remainder
   logic [DATA_W-1:0] dvs_q, dvs_d;       // divisor magnitude
   logic [DATA_W-1:0] dvdMag_q, dvdMag_d; // dividend magnitude, kept for special cases
   logic              negQ_q, negQ_d;
   logic              negR_q, negR_d;
   logic              isRem_q, isRem_d;
   logic              divZero_q, divZero_d;
   logic              ovf_q, ovf_d;
   logic [TAG_W-1:0]  alID_q, alID_d;
   logic [PHY_W-1:0]  phyDest_q, phyDest_d;

   logic              accept;
   logic              lastStep;
   logic              negA, negB;
   logic [DATA_W-1:0] magA, magB;
   logic              inDivZero, inOvf;
   logic [DATA_W:0]   partial, diff;
   logic [DATA_W-1:0] qFinal, rFinal;

   assign accept   = bus.valid_i && (state_q == S_IDLE) && !bus.recoverFlag_i;
   assign lastStep = (cnt_q == CNT_LAST);

   // Operand decode at issue
   assign negA      = bus.isSigned_i && bus.src1Data_i[DATA_W-1];
   assign negB      = bus.isSigned_i && bus.src2Data_i[DATA_W-1];
   assign magA      = f_cond_neg(bus.src1Data_i, negA);
   assign magB      = f_cond_neg(bus.src2Data_i, negB);
   assign inDivZero = (bus.src2Data_i == '0);
   assign inOvf     = bus.isSigned_i && (bus.src1Data_i == MOST_NEG) &&
                      (bus.src2Data_i == '1);

   // One restoring step: bring in next dividend bit, trial-subtract divisor.
   // The top bit of diff is the borrow; if set the subtraction is discarded.
   assign partial = {rem_q, quo_q[DATA_W-1]};
   assign diff    = partial - {1'b0, dvs_q};

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic (flush has priority in every state)
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (bus.recoverFlag_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.valid_i) begin
`ifdef ITER_DIV_EARLY_OUT_EN
                  state_d = (inDivZero || inOvf) ? S_DONE : S_BUSY;
`else
                  state_d = S_BUSY;
`endif
               end
            end
            S_BUSY: begin
               if (lastStep) begin
                  state_d = S_DONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Datapath next-state
   // -------------------------------------------------------------------------
   always_comb begin
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      dvdMag_d  = dvdMag_q;
      negQ_d    = negQ_q;
      negR_d    = negR_q;
      isRem_d   = isRem_q;
      divZero_d = divZero_q;
      ovf_d     = ovf_q;
      alID_d    = alID_q;
      phyDest_d = phyDest_q;

      if (accept) begin
         cnt_d     = '0;
         quo_d     = magA;
         rem_d     = '0;
         dvs_d     = magB;
         dvdMag_d  = magA;
         negQ_d    = negA ^ negB;
         negR_d    = negA;
         isRem_d   = bus.isRem_i;
         divZero_d = inDivZero;
         ovf_d     = inOvf;
         alID_d    = bus.alID_i;
         phyDest_d = bus.phyDest_i;
      end else if (state_q == S_BUSY && !bus.recoverFlag_i) begin
         cnt_d = cnt_q + DATA_W'(1);
         quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
         rem_d = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         dvdMag_q  <= '0;
         negQ_q    <= 1'b0;
         negR_q    <= 1'b0;
         isRem_q   <= 1'b0;
         divZero_q <= 1'b0;
         ovf_q     <= 1'b0;
         alID_q    <= '0;
         phyDest_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         dvdMag_q  <= dvdMag_d;
         negQ_q    <= negQ_d;
         negR_q    <= negR_d;
         isRem_q   <= isRem_d;
         divZero_q <= divZero_d;
         ovf_q     <= ovf_d;
         alID_q    <= alID_d;
         phyDest_q <= phyDest_d;
      end
   end

   // Final results. Special cases are taken from the latched operands so the
   // same path serves both the early-out and full-iteration builds.
   // Overflow: |MOST_NEG| is MOST_NEG itself, which is the required quotient.
   always_comb begin
      if (divZero_q) begin
         qFinal = '1;
         rFinal = f_cond_neg(dvdMag_q, negR_q);
      end else if (ovf_q) begin
         qFinal = dvdMag_q;
         rFinal = '0;
      end else begin
         qFinal = f_cond_neg(quo_q, negQ_q);
         rFinal = f_cond_neg(rem_q, negR_q);
      end
   end

   // -------------------------------------------------------------------------
   // FSM: outputs (result fields are forced to zero outside the pulse;
   // a flush in DONE suppresses the pulse in that same cycle)
   // -------------------------------------------------------------------------
   always_comb begin
      bus.ready_o       = (state_q == S_IDLE);
      bus.resultValid_o = (state_q == S_DONE) && !bus.recoverFlag_i;
      bus.result_o      = '0;
      bus.alID_o        = '0;
      bus.phyDest_o     = '0;
      if (bus.resultValid_o) begin
         bus.result_o  = isRem_q ? rFinal : qFinal;
         bus.alID_o    = alID_q;
         bus.phyDest_o = phyDest_q;
      end
   end

endmodule

// File: tb/tb_iter_div_unit.sv
module tb_iter_div_unit;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 7;
   localparam int PHY_W  = 7;
   localparam int FULL_LAT = DATA_W + 1;
`ifdef ITER_DIV_EARLY_OUT_EN
   localparam int SPECIAL_LAT = 1;
`else
   localparam int SPECIAL_LAT = DATA_W + 1;
`endif

   typedef struct {
      logic [31:0] res;
      logic [6:0]  alid;
      logic [6:0]  phy;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb[$];

   iter_div_unit_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .PHY_W(PHY_W)) bus ();

   iter_div_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W), .PHY_W(PHY_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model using the language's own division (truncating toward zero)
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn, input logic rem);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
      end else if (sgn) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end else begin
         q = a / b;
         r = a % b;
      end
      return rem ? r : q;
   endfunction

   task automatic idle_inputs();
      bus.valid_i       = 1'b0;
      bus.recoverFlag_i = 1'b0;
      bus.src1Data_i    = $urandom;
      bus.src2Data_i    = $urandom;
      bus.isSigned_i    = 1'($urandom_range(0, 1));
      bus.isRem_i       = 1'($urandom_range(0, 1));
      bus.alID_i        = 7'($urandom);
      bus.phyDest_i     = 7'($urandom);
   endtask

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic rem, input logic [6:0] alid, input logic [6:0] phy);
      bus.valid_i    = 1'b1;
      bus.src1Data_i = a;
      bus.src2Data_i = b;
      bus.isSigned_i = sgn;
      bus.isRem_i    = rem;
      bus.alID_i     = alid;
      bus.phyDest_i  = phy;
   endtask

   task automatic watch_quiet(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.resultValid_o !== 1'b0) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic rem, input logic [6:0] alid,
                         input logic [6:0] phy);
      exp_t e;
      exp_t got;
      int   lat;
      logic rdyHigh;
      logic special;
      special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      e.res  = model(a, b, sgn, rem);
      e.alid = alid;
      e.phy  = phy;
      e.lat  = special ? SPECIAL_LAT : FULL_LAT;
      sb.push_back(e);
      chk({tag, " ready_before"}, 32'(bus.ready_o), 32'd1);
      drive_op(a, b, sgn, rem, alid, phy);
      @(posedge clk);
      #1;
      idle_inputs();
      lat = 1;
      rdyHigh = 1'b0;
      while (bus.resultValid_o !== 1'b1 && lat < 100) begin
         if (bus.ready_o !== 1'b0) rdyHigh = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " resultValid_seen"}, 32'(bus.resultValid_o), 32'd1);
      if (sb.size() != 0) begin
         got = sb.pop_front();
         chk({tag, " result"}, bus.result_o, got.res);
         chk({tag, " alID"}, 32'(bus.alID_o), 32'(got.alid));
         chk({tag, " phyDest"}, 32'(bus.phyDest_o), 32'(got.phy));
         chk({tag, " latency"}, 32'(lat), 32'(got.lat));
      end
      chk({tag, " ready_low_while_busy"}, 32'(rdyHigh), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " pulse_one_cycle"}, 32'(bus.resultValid_o), 32'd0);
      chk({tag, " result_zero_after"}, bus.result_o, 32'd0);
      chk({tag, " ready_after"}, 32'(bus.ready_o), 32'd1);
   endtask

   initial begin
      idle_inputs();
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset ready", 32'(bus.ready_o), 32'd1);
      chk("reset resultValid", 32'(bus.resultValid_o), 32'd0);
      chk("reset result", bus.result_o, 32'd0);
      chk("reset alID", 32'(bus.alID_o), 32'd0);
      chk("reset phyDest", 32'(bus.phyDest_o), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Main function
      run_op("u100div7",   32'd100,         32'd7,         1'b0, 1'b0, 7'd5,  7'd17);
      run_op("s-7rem2",    32'hFFFF_FFF9,   32'd2,         1'b1, 1'b1, 7'd6,  7'd33);
      run_op("s-7div2",    32'hFFFF_FFF9,   32'd2,         1'b1, 1'b0, 7'd7,  7'd34);
      run_op("s7rem-2",    32'd7,           32'hFFFF_FFFE, 1'b1, 1'b1, 7'd8,  7'd35);
      run_op("uFFFFdiv3",  32'hFFFF_FFFF,   32'd3,         1'b0, 1'b0, 7'd9,  7'd36);
      run_op("s-100div-9", 32'hFFFF_FF9C,   32'hFFFF_FFF7, 1'b1, 1'b0, 7'd10, 7'd37);
      run_op("u8000rem7",  32'h8000_0000,   32'd7,         1'b0, 1'b1, 7'd11, 7'd38);

      // Special cases
      run_op("div0_q",     32'h0000_1234,   32'd0,         1'b0, 1'b0, 7'd12, 7'd40);
      run_op("div0_r",     32'h0000_1234,   32'd0,         1'b0, 1'b1, 7'd13, 7'd41);
      run_op("sdiv0_neg_q",32'hFFFF_FFFB,   32'd0,         1'b1, 1'b0, 7'd14, 7'd42);
      run_op("sdiv0_neg_r",32'hFFFF_FFFB,   32'd0,         1'b1, 1'b1, 7'd15, 7'd43);
      run_op("ovf_q",      32'h8000_0000,   32'hFFFF_FFFF, 1'b1, 1'b0, 7'd16, 7'd44);
      run_op("ovf_r",      32'h8000_0000,   32'hFFFF_FFFF, 1'b1, 1'b1, 7'd17, 7'd45);

      // Flush at BUSY step 10
      drive_op(32'd100, 32'd7, 1'b0, 1'b0, 7'd20, 7'd50);
      @(posedge clk);
      #1;
      idle_inputs();
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      chk("flush busy_before", 32'(bus.ready_o), 32'd0);
      bus.recoverFlag_i = 1'b1;
      @(posedge clk);
      #1;
      bus.recoverFlag_i = 1'b0;
      chk("flush ready_next", 32'(bus.ready_o), 32'd1);
      watch_quiet("flush no_result", 40);
      run_op("after_flush 9div3", 32'd9, 32'd3, 1'b0, 1'b0, 7'd21, 7'd51);

      // valid and flush together in IDLE
      drive_op(32'd50, 32'd5, 1'b0, 1'b0, 7'd22, 7'd52);
      bus.recoverFlag_i = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      chk("valid+flush ready", 32'(bus.ready_o), 32'd1);
      watch_quiet("valid+flush no_result", 40);

      // Asynchronous reset mid-BUSY
      drive_op(32'd1000, 32'd3, 1'b0, 1'b0, 7'd23, 7'd53);
      @(posedge clk);
      #1;
      idle_inputs();
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("midreset ready", 32'(bus.ready_o), 32'd1);
      chk("midreset resultValid", 32'(bus.resultValid_o), 32'd0);
      chk("midreset result", bus.result_o, 32'd0);
      chk("midreset alID", 32'(bus.alID_o), 32'd0);
      chk("midreset phyDest", 32'(bus.phyDest_o), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #4;
      reset = 1'b0;
      watch_quiet("midreset no_stale_result", 40);
      run_op("after_reset 9div3", 32'd9, 32'd3, 1'b1, 1'b0, 7'd24, 7'd54);

      chk("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
